// File: rtl/mem_stage.sv
// Memory-access pipeline stage: collects load/store responses, shapes load
// data, and hands entries to WB; drops responses of flushed entries.
module mem_stage #(
   parameter int EX2MEM_LEN = 212,
   parameter int MEM2WB_LEN = 207
) (
   input  logic                  clk,
   input  logic                  resetn,
   output logic                  mem_allowin,
   input  logic                  exe_to_mem_valid,
   input  logic [EX2MEM_LEN-1:0] exe_to_mem_zip,
   input  logic                  wb_allowin,
   output logic                  mem_to_wb_valid,
   output logic [MEM2WB_LEN-1:0] mem_to_wb_zip,
   input  logic                  data_sram_data_ok,
   input  logic [31:0]           data_sram_rdata,
   output logic [38:0]           mem_rf_zip,
   output logic                  mem_ex,
   input  logic                  wb_ex
);

   localparam int RES_BIT = EX2MEM_LEN - 1;
   localparam int OP_LO   = EX2MEM_LEN - 4;
   localparam int REQ_BIT = EX2MEM_LEN - 5;
   localparam int RF_WE   = MEM2WB_LEN - 1;
   localparam int WA_LO   = MEM2WB_LEN - 6;
   localparam int WD_LO   = MEM2WB_LEN - 38;
   localparam int CSR_RD  = 136;
   localparam int CSR_WE  = 135;
   localparam int EX_BIT  = 24;
   localparam int ERTN    = 8;
   localparam int TLB_LO  = 5;
   localparam logic [2:0] TLB_OP_NONE = 3'd0;

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t                state;
   logic                  mem_valid;
   logic                  buf_valid;
   logic                  res_r;
   logic                  req_r;
   logic [2:0]            op_r;
   logic [31:0]           data_buf;
   logic [MEM2WB_LEN-1:0] wb_r;

   logic        v;
   logic        ok;
   logic        ready_go;
   logic        leave;
   logic        accept;
   logic [1:0]  off;
   logic [31:0] src;
   logic [31:0] ld;
   logic [31:0] wdata;
   logic [7:0]  b;
   logic [15:0] h;

   // A response only belongs to the entry while it is waiting for one.
   assign ok       = data_sram_data_ok & (state == WAIT);
   assign v        = mem_valid & resetn;
   assign ready_go = ~req_r | ok | buf_valid;
   assign leave    = v & ready_go & wb_allowin;

   assign mem_allowin = ~resetn
                      | (state != DISCARD)
                        & (~mem_valid | ready_go & wb_allowin);

   assign accept = exe_to_mem_valid & mem_allowin & resetn & ~wb_ex;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         mem_valid <= 1'b0;
         buf_valid <= 1'b0;
         data_buf  <= '0;
         res_r     <= 1'b0;
         req_r     <= 1'b0;
         op_r      <= '0;
         wb_r      <= '0;
         wb_r[TLB_LO+:3] <= TLB_OP_NONE;
      end else if (wb_ex) begin
         mem_valid <= 1'b0;
         buf_valid <= 1'b0;
         if (state == WAIT && !data_sram_data_ok && !buf_valid)
            state <= DISCARD;
         else if (state == DISCARD && !data_sram_data_ok)
            state <= DISCARD;
         else
            state <= IDLE;
      end else begin
         if (state == DISCARD && data_sram_data_ok)
            state <= IDLE;
         if (ok && !leave) begin
            buf_valid <= 1'b1;
            data_buf  <= data_sram_rdata;
         end
         if (leave) begin
            mem_valid <= 1'b0;
            buf_valid <= 1'b0;
            if (state == WAIT)
               state <= IDLE;
         end
         if (accept) begin
            mem_valid <= 1'b1;
            buf_valid <= 1'b0;
            res_r     <= exe_to_mem_zip[RES_BIT];
            op_r      <= exe_to_mem_zip[OP_LO+:3];
            req_r     <= exe_to_mem_zip[REQ_BIT];
            wb_r      <= exe_to_mem_zip[MEM2WB_LEN-1:0];
            state     <= exe_to_mem_zip[REQ_BIT] ? WAIT : IDLE;
         end
      end
   end

   always_comb begin
      src = buf_valid ? data_buf : data_sram_rdata;
      off = wb_r[WD_LO+:2];
      b   = src[{off, 3'b000} +: 8];
      h   = off[1] ? src[31:16] : src[15:0];
      case (op_r)
         3'd1:    ld = {{24{b[7]}}, b};
         3'd2:    ld = {24'd0, b};
         3'd3:    ld = {{16{h[15]}}, h};
         3'd4:    ld = {16'd0, h};
         default: ld = src;
      endcase
      wdata = res_r ? ld : wb_r[WD_LO+:32];
      mem_to_wb_zip = wb_r;
      mem_to_wb_zip[WD_LO+:32] = wdata;
   end

   assign mem_to_wb_valid = v & ready_go & ~wb_ex;
   assign mem_ex = v & (wb_r[EX_BIT] | wb_r[ERTN]);

   assign mem_rf_zip = resetn ? {
      v & (res_r & ~ready_go | wb_r[CSR_RD] | wb_r[CSR_WE]),
      v & wb_r[RF_WE] & ~wb_r[EX_BIT] & ~wb_r[ERTN],
      wb_r[WA_LO+:5],
      wdata
   } : 39'd0;

endmodule
